// File: rtl/sync_filter_bus.sv
// Multi-channel synchroniser + glitch filter into the outclk domain.
// Define SYNC_FILTER_EDGE_EN to build the registered orise/ofall pulse flops; otherwise they read 0.

module sync_filter_chan #(
  parameter int unsigned kStages    = 2,
  parameter int unsigned kFilterLen = 4,
  parameter logic        kResetBit  = 1'b0
) (
  input  logic outclk,
  input  logic aresetn,
  input  logic ain,
  output logic oout,
  output logic orise,
  output logic ofall,
  output logic quiet
);
  localparam int CW = $clog2(kFilterLen + 1);

  logic [kStages-1:0] sync;
  logic [CW-1:0]      cnt;
  logic               s;
  logic               take;

  assign s     = sync[kStages-1];
  assign take  = (s != oout) && (cnt == CW'(kFilterLen - 1));
  assign quiet = (cnt == '0) && (s == oout);

  // sync[0] is the only flop that ever sees ain directly
  always_ff @(posedge outclk or negedge aresetn) begin
    if (!aresetn) begin
      sync <= {kStages{kResetBit}};
      oout <= kResetBit;
      cnt  <= '0;
    end else begin
      sync <= {sync[kStages-2:0], ain};
      if (s == oout) begin
        cnt <= '0;
      end else if (take) begin
        oout <= s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef SYNC_FILTER_EDGE_EN
  // pulses share the edge that updates oout, so they line up with the new level
  always_ff @(posedge outclk or negedge aresetn) begin
    if (!aresetn) begin
      orise <= 1'b0;
      ofall <= 1'b0;
    end else begin
      orise <= take & s;
      ofall <= take & ~s;
    end
  end
`else
  assign orise = 1'b0;
  assign ofall = 1'b0;
`endif
endmodule

module sync_filter_bus #(
  parameter int unsigned        kWidth     = 4,
  parameter int unsigned        kStages    = 2,
  parameter int unsigned        kFilterLen = 4,
  parameter logic [kWidth-1:0]  kResetTo   = '0
) (
  input  logic              outclk,
  input  logic              aresetn,
  input  logic [kWidth-1:0] ain,
  output logic [kWidth-1:0] oout,
  output logic [kWidth-1:0] orise,
  output logic [kWidth-1:0] ofall,
  output logic              osettled
);
  if (kStages < 2) begin : g_bad_stages
    $error("sync_filter_bus: kStages must be >= 2");
  end
  if (kFilterLen < 1) begin : g_bad_filter
    $error("sync_filter_bus: kFilterLen must be >= 1");
  end

  logic [kWidth-1:0] quiet;

  for (genvar i = 0; i < kWidth; i++) begin : g_chan
    sync_filter_chan #(
      .kStages   (kStages),
      .kFilterLen(kFilterLen),
      .kResetBit (kResetTo[i])
    ) u_chan (
      .outclk (outclk),
      .aresetn(aresetn),
      .ain    (ain[i]),
      .oout   (oout[i]),
      .orise  (orise[i]),
      .ofall  (ofall[i]),
      .quiet  (quiet[i])
    );
  end

  always_ff @(posedge outclk or negedge aresetn) begin
    if (!aresetn) osettled <= 1'b1;
    else          osettled <= &quiet;
  end
endmodule

// File: tb/tb_sync_filter_bus.sv
// Directed bench for sync_filter_bus (kWidth=4, kStages=2, kFilterLen=4, kResetTo=4'b0101).
// Expected pulses follow SYNC_FILTER_EDGE_EN; with it undefined orise/ofall must stay 0.

module tb_sync_filter_bus;
`ifdef SYNC_FILTER_EDGE_EN
  localparam logic [3:0] EM = 4'hF;
`else
  localparam logic [3:0] EM = 4'h0;
`endif
  localparam logic [3:0] RST = 4'b0101;

  logic       outclk = 1'b0;
  logic       aresetn;
  logic [3:0] ain;
  logic [3:0] oout, orise, ofall;
  logic       osettled;
  int         n_vec = 0;
  int         n_bad = 0;

  sync_filter_bus #(.kWidth(4), .kStages(2), .kFilterLen(4), .kResetTo(RST)) dut (
    .outclk  (outclk),
    .aresetn (aresetn),
    .ain     (ain),
    .oout    (oout),
    .orise   (orise),
    .ofall   (ofall),
    .osettled(osettled)
  );

  always #5 outclk = ~outclk;

  task automatic step();
    @(posedge outclk);
    #1;
  endtask

  task automatic settle(input logic [3:0] v);
    ain = v;
    repeat (12) step();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    ain     = 4'hF;
    repeat (3) step();
    n_vec++; if (oout !== RST) begin n_bad++; $display("FAIL reset_oout got=%b want=%b", oout, RST); end
    n_vec++; if (orise !== 4'h0 || ofall !== 4'h0) begin n_bad++; $display("FAIL reset_pulses got rise=%b fall=%b want 0", orise, ofall); end
    n_vec++; if (osettled !== 1'b1) begin n_bad++; $display("FAIL reset_settled got=%b want=1", osettled); end
    aresetn = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      logic [3:0] eo, er;
      logic       es;
      step();
      eo = (k >= 5) ? 4'hF : RST;
      er = (k == 5) ? (4'b1010 & EM) : 4'h0;
      es = !(k >= 2 && k <= 5);
      n_vec++; if (oout !== eo) begin n_bad++; $display("FAIL rel_oout E0+%0d got=%b want=%b", k, oout, eo); end
      n_vec++; if (orise !== er || ofall !== 4'h0) begin n_bad++; $display("FAIL rel_pulse E0+%0d rise=%b fall=%b want rise=%b fall=0000", k, orise, ofall, er); end
      n_vec++; if (osettled !== es) begin n_bad++; $display("FAIL rel_settled E0+%0d got=%b want=%b", k, osettled, es); end
    end
  endtask

  task automatic test_latency();
    settle(4'h0);
    n_vec++; if (oout !== 4'h0) begin n_bad++; $display("FAIL lat_pre got=%b want=0000", oout); end
    ain[0] = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      logic [3:0] eo, er;
      logic       es;
      step();
      eo = (k >= 5) ? 4'b0001 : 4'b0000;
      er = (k == 5) ? (4'b0001 & EM) : 4'h0;
      es = !(k >= 2 && k <= 5);
      n_vec++; if (oout !== eo) begin n_bad++; $display("FAIL lat_oout E0+%0d got=%b want=%b", k, oout, eo); end
      n_vec++; if (orise !== er || ofall !== 4'h0) begin n_bad++; $display("FAIL lat_pulse E0+%0d rise=%b fall=%b want rise=%b fall=0000", k, orise, ofall, er); end
      n_vec++; if (osettled !== es) begin n_bad++; $display("FAIL lat_settled E0+%0d got=%b want=%b", k, osettled, es); end
    end
  endtask

  task automatic test_glitch();
    settle(4'h0);
    // 2-cycle pulse: never reaches the filter length
    ain[2] = 1'b1;
    step(); step();
    ain[2] = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      step();
      n_vec++; if (oout !== 4'h0 || orise !== 4'h0 || ofall !== 4'h0)
        begin n_bad++; $display("FAIL glitch_short E0+%0d oout=%b rise=%b fall=%b want all 0", k, oout, orise, ofall); end
    end
    // 6-cycle pulse: accepted, high for 6 cycles
    ain[2] = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      logic [3:0] eo, er, ef;
      step();
      if (k == 5) ain[2] = 1'b0;
      eo = (k >= 5 && k <= 10) ? 4'b0100 : 4'b0000;
      er = (k == 5)  ? (4'b0100 & EM) : 4'h0;
      ef = (k == 11) ? (4'b0100 & EM) : 4'h0;
      n_vec++; if (oout !== eo) begin n_bad++; $display("FAIL glitch_long_oout E0+%0d got=%b want=%b", k, oout, eo); end
      n_vec++; if (orise !== er || ofall !== ef) begin n_bad++; $display("FAIL glitch_long_pulse E0+%0d rise=%b fall=%b want rise=%b fall=%b", k, orise, ofall, er, ef); end
    end
  endtask

  task automatic test_simultaneous();
    settle(4'h0);
    ain = 4'hF;
    for (int k = 0; k <= 7; k++) begin
      logic [3:0] eo, er;
      step();
      eo = (k >= 5) ? 4'hF : 4'h0;
      er = (k == 5) ? EM : 4'h0;
      n_vec++; if (oout !== eo) begin n_bad++; $display("FAIL simul_oout E0+%0d got=%b want=%b", k, oout, eo); end
      n_vec++; if (orise !== er || ofall !== 4'h0) begin n_bad++; $display("FAIL simul_pulse E0+%0d rise=%b fall=%b want rise=%b fall=0000", k, orise, ofall, er); end
    end
  endtask

  task automatic test_reset_midcount();
    settle(4'h0);
    ain[1] = 1'b1;
    step(); step(); step(); step();   // observing after E0+3
    n_vec++; if (oout !== 4'h0) begin n_bad++; $display("FAIL mid_precount got=%b want=0000", oout); end
    aresetn = 1'b0;
    #1;
    n_vec++; if (oout !== RST || orise !== 4'h0 || ofall !== 4'h0 || osettled !== 1'b1)
      begin n_bad++; $display("FAIL mid_async oout=%b rise=%b fall=%b settled=%b want %b/0000/0000/1", oout, orise, ofall, osettled, RST); end
    step(); step();
    aresetn = 1'b1;
    // ain=0010 still differs from RST on bits 0,1,2: full latency restarts
    for (int k = 0; k <= 7; k++) begin
      logic [3:0] eo, er, ef;
      step();
      eo = (k >= 5) ? 4'b0010 : RST;
      er = (k == 5) ? (4'b0010 & EM) : 4'h0;
      ef = (k == 5) ? (4'b0101 & EM) : 4'h0;
      n_vec++; if (oout !== eo) begin n_bad++; $display("FAIL mid_oout E0+%0d got=%b want=%b", k, oout, eo); end
      n_vec++; if (orise !== er || ofall !== ef) begin n_bad++; $display("FAIL mid_pulse E0+%0d rise=%b fall=%b want rise=%b fall=%b", k, orise, ofall, er, ef); end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    ain     = 4'hF;
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_filter_bus.md
# sync_filter_bus

Multi-channel, parametrised successor to the single-bit synchroniser. It brings a `kWidth`-bit bundle of asynchronous level signals (HDMI hot-plug, DDC lines, cable-detect, button inputs) into the `outclk` domain. Each channel gets a configurable-depth synchroniser chain, followed by a per-channel glitch filter that only accepts a new level after it has been stable for `kFilterLen` cycles. Optional edge pulses are provided for downstream FSMs. The block sits at the boundary between board-level inputs and the video/control logic clocked by `outclk`.

## Interface
- `kWidth`, 4: number of independent channels.
- `kStages`, 2: synchroniser flops per channel; must be ≥2 (elaboration error otherwise).
- `kFilterLen`, 4: consecutive stable cycles required before the output accepts a new level; must be ≥1; `kFilterLen`=1 disables filtering.
- `kResetTo`, 0: `kWidth`-bit reset value for sync stages and `oout`.

Ports:
- `outclk`  in  1  destination clock; all state on its rising edge.
- `aresetn`  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion must be synchronous to `outclk` (supplied externally).
- `ain`  in  kWidth  asynchronous level inputs, no timing relation to `outclk`.
- `oout`  out  kWidth  synchronised, filtered levels.
- `orise`  out  kWidth  one-cycle pulse per channel when `oout[i]` goes 0→1.
- `ofall`  out  kWidth  one-cycle pulse per channel when `oout[i]` goes 1→0.
- `osettled`  out  1  high when no channel has a pending (counting) change.

## Operation
- Per channel `i`: a chain of `kStages` flops. `s[i]` is the last stage. The first stage is the only flop sampling `ain`, and it is the only metastability point.
- Filter per channel: counter `cnt[i]`, width `$clog2(kFilterLen+1)`. Every edge:
  - `s[i]==oout[i]` → `cnt[i]<=0`.
  - else if `cnt[i]==kFilterLen-1` → `oout[i]<=s[i]`, `cnt[i]<=0`, assert `orise[i]` if `s[i]`=1, else `ofall[i]`.
  - else → `cnt[i]<=cnt[i]+1`.
- Glitch: if `s[i]` returns to `oout[i]` before the count completes, the counter clears. No output change and no pulse.
- Channels are fully independent. Simultaneous changes on several channels update in the same cycle, each with its own pulse.
- `orise`/`ofall` are registered. They are high only in the cycle in which `oout` shows the new value, and are cleared the following edge unless that channel updates again (impossible with `kFilterLen`≥1 and a stable `s`).
- `osettled` is registered: 1 iff every `cnt[i]==0` and every `s[i]==oout[i]`, as evaluated on the previous edge's state.
- Reset (async, any time, including mid-count): all sync stages and `oout` go to `kResetTo`; all `cnt` go to 0; `orise`, `ofall` go to 0; `osettled` goes to 1. No pulses are generated by reset entry or exit.

## Timing
- Let E0 be the edge at which the first stage captures a new stable `ain[i]`.
- `s[i]` changes after edge E0+`kStages`-1.
- `oout[i]` and its pulse change after edge E0+`kStages`+`kFilterLen`-1. Example: `kStages`=2, `kFilterLen`=4 gives E0+5; `kFilterLen`=1 gives E0+`kStages`.
- Minimum accepted pulse width on `ain`: `kFilterLen` `outclk` periods plus capture uncertainty of one cycle. Shorter pulses are rejected.
- Throughput: one accepted transition per channel every `kFilterLen` cycles at most.

## Configuration
- `SYNC_FILTER_EDGE_EN` defined: `orise`/`ofall` pulse flops are implemented as described.
- Not defined: `orise` and `ofall` are tied to 0 and no edge flops are generated. `oout`, `osettled` and the filter are unchanged.

## Test plan
- Reset (defaults, `kResetTo`=4'b0101): hold `aresetn`=0 with `ain`=4'hF → `oout`=4'b0101, `orise`=`ofall`=0, `osettled`=1. Release → after 5 edges `oout`=4'hF, with `orise`=4'b1010 for exactly one cycle.
- Latency: `ain[0]` 0→1 captured at E0 → `oout[0]` rises after E0+5, and `orise[0]` is high only in that cycle; `osettled` is low from E0+2 through E0+5.
- Glitch: `ain[2]` pulsed high for 2 cycles → `oout[2]` stays 0, no `orise`; a 6-cycle pulse → `oout[2]` high for 6 cycles, and `orise[2]` and `ofall[2]` each pulse once.
- Simultaneous: `ain` 4'h0→4'hF in one cycle → all `oout` bits rise on the same edge, `orise`=4'hF for one cycle.
- Reset mid-count: `ain[1]` change, assert `aresetn`=0 at E0+3 → `oout[1]`=`kResetTo[1]` immediately, `cnt` cleared, no pulse on release unless `ain[1]` still differs, in which case the full latency restarts.
- Macro off: same stimulus as the latency scenario → identical `oout`, `orise`=`ofall`=0 throughout.
